aes_inv_mix_columns_seq: RTL and testbench



---
 rtl/aes_inv_mix_columns_seq.sv | 129 ++++++++++++
 tb/tb_aes_inv_mix_columns_seq.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_mix_columns_seq.sv
// AES InvMixColumns over a 128-bit state.
// One column per clock through a shared GF(2^8) unit.
module aes_inv_mix_columns_seq #(
  parameter int NCOL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  typedef enum logic [1:0] {
    S_RST,
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  localparam logic [1:0] LAST = 2'(NCOL - 1);

  state_t       state_q;
  state_t       state_d;
  logic [127:0] src_reg;
  logic [127:0] res_reg;
  logic         byp_reg;
  logic [1:0]   col_cnt;
  logic [31:0]  col_in;
  logic [31:0]  col_mix;
  logic [31:0]  col_out;

  function automatic logic [7:0] xt(
    input logic [7:0] v
  );
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m09(
    input logic [7:0] v
  );
    return xt(xt(xt(v))) ^ v;
  endfunction

  function automatic logic [7:0] m0b(
    input logic [7:0] v
  );
    return xt(xt(xt(v))) ^ xt(v) ^ v;
  endfunction

  function automatic logic [7:0] m0d(
    input logic [7:0] v
  );
    return xt(xt(xt(v))) ^ xt(xt(v)) ^ v;
  endfunction

  function automatic logic [7:0] m0e(
    input logic [7:0] v
  );
    return xt(xt(xt(v))) ^ xt(xt(v)) ^ xt(v);
  endfunction

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_state = res_reg;

  // select the column currently being processed
  always_comb begin
    col_in = src_reg[127 - 32*int'(col_cnt) -: 32];
  end

  // shared inverse-mix column unit, with bypass
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    a0 = col_in[31:24];
    a1 = col_in[23:16];
    a2 = col_in[15:8];
    a3 = col_in[7:0];
    col_mix = {
      m0e(a0) ^ m0b(a1) ^ m0d(a2) ^ m09(a3),
      m09(a0) ^ m0e(a1) ^ m0b(a2) ^ m0d(a3),
      m0d(a0) ^ m09(a1) ^ m0e(a2) ^ m0b(a3),
      m0b(a0) ^ m0d(a1) ^ m09(a2) ^ m0e(a3)
    };
    col_out = byp_reg ? col_in : col_mix;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST:  state_d = S_IDLE;
      S_IDLE: if (in_valid) state_d = S_CALC;
      S_CALC: if (col_cnt == LAST) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_RST;
    endcase
  end

  // capture input and accumulate result columns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_reg <= '0;
      res_reg <= '0;
      byp_reg <= 1'b0;
      col_cnt <= '0;
    end else begin
      if (state_q == S_IDLE && in_valid) begin
        src_reg <= in_state;
        byp_reg <= in_bypass;
        col_cnt <= '0;
      end
      if (state_q == S_CALC) begin
        res_reg[127 - 32*int'(col_cnt) -: 32] <= col_out;
        col_cnt <= col_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_inv_mix_columns_seq.sv
// Directed and random checks for
// aes_inv_mix_columns_seq.
module tb_aes_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         in_bypass = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] VEC_IN =
    128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] VEC_OUT =
    128'hdb135345_f20a225c_01010101_d4d4d4d5;

  always #5 clk = ~clk;

  aes_inv_mix_columns_seq #(.NCOL(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_bypass (in_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  function automatic logic [7:0] gmul(
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [7:0] p;
    logic [7:0] a;
    logic [7:0] b;
    p = 8'h00;
    a = x;
    b = y;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      if (a[7]) a = (a << 1) ^ 8'h1b;
      else      a = a << 1;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mat_apply(
    input logic [127:0] s,
    input logic [31:0]  coefs
  );
    logic [127:0] r;
    logic [7:0]   cf [4];
    logic [7:0]   a  [4];
    logic [7:0]   acc;
    r = '0;
    for (int k = 0; k < 4; k++)
      cf[k] = coefs[31 - 8*k -: 8];
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++)
        a[k] = s[127 - 32*c - 8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(cf[(k - row) & 3], a[k]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_inv(
    input logic [127:0] s
  );
    return mat_apply(s, 32'h0e0b0d09);
  endfunction

  function automatic logic [127:0] ref_fwd(
    input logic [127:0] s
  );
    return mat_apply(s, 32'h02030101);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present one state and hold until accepted
  task automatic send(
    input logic [127:0] s,
    input logic         byp
  );
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout in_ready=%0b required=1",
               in_ready);
    end
    in_valid  = 1'b1;
    in_state  = s;
    in_bypass = byp;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs in_ready=%0b out_valid=%0b required=0/0",
               in_ready, out_valid);
    end
    checks++;
    if (out_state !== 128'h0) begin
      failures++;
      $display("FAIL reset_state got=%h required=0", out_state);
    end
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_pre_edge in_ready=%0b required=0", in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle in_ready=%0b required=1", in_ready);
    end
  endtask

  task automatic run_one(
    input string        name,
    input logic         byp,
    input logic [127:0] exp
  );
    int lat;
    out_ready = 1'b1;
    send(VEC_IN, byp);
    wait_valid(lat);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL %s_latency got=%0d required=4", name, lat);
    end
    checks++;
    if (out_state !== exp) begin
      failures++;
      $display("FAIL %s_data got=%h required=%h", name, out_state, exp);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_after out_valid=%0b in_ready=%0b required=0/1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    run_one("basic", 1'b0, VEC_OUT);
  endtask

  task automatic test_bypass();
    run_one("bypass", 1'b1, VEC_IN);
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    out_ready = 1'b0;
    send(VEC_IN, 1'b0);
    wait_valid(lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_state !== VEC_OUT) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_stable bad_cycles=%0d required=0", bad);
    end
    checks++;
    if (out_valid !== 1'b1 || out_state !== VEC_OUT) begin
      failures++;
      $display("FAIL bp_hold out_valid=%0b got=%h required=1/%h",
               out_valid, out_state, VEC_OUT);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release out_valid=%0b in_ready=%0b required=0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] s [3];
    logic [127:0] got [3];
    int acc_cyc [3];
    int out_cyc [3];
    int ai;
    int oi;
    int cyc;
    logic acc;
    logic xfer;
    s[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
    s[1] = VEC_IN;
    s[2] = 128'hdeadbeef_01234567_89abcdef_f0e1d2c3;
    ai = 0;
    oi = 0;
    cyc = 0;
    out_ready = 1'b1;
    in_bypass = 1'b0;
    in_valid  = 1'b1;
    in_state  = s[0];
    while (oi < 3 && cyc < 60) begin
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        got[oi] = out_state;
        out_cyc[oi] = cyc;
        oi++;
      end
      step();
      cyc++;
      if (acc) begin
        acc_cyc[ai] = cyc;
        ai++;
        if (ai < 3) in_state = s[ai];
        else        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (oi != 3) begin
      failures++;
      $display("FAIL b2b_count got=%0d required=3", oi);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== ref_inv(s[i])) begin
          failures++;
          $display("FAIL b2b_data%0d got=%h required=%h",
                   i, got[i], ref_inv(s[i]));
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (out_cyc[i] - out_cyc[i-1] != 6) begin
          failures++;
          $display("FAIL b2b_gap%0d got=%0d required=6",
                   i, out_cyc[i] - out_cyc[i-1]);
        end
      end
      checks++;
      if (acc_cyc[1] <= out_cyc[0]) begin
        failures++;
        $display("FAIL b2b_order accept2=%0d out1=%0d required=later",
                 acc_cyc[1], out_cyc[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    int lat;
    out_ready = 1'b1;
    send(VEC_IN, 1'b0);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_state !== 128'h0 ||
        in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_clear ov=%0b st=%h ir=%0b required=0/0/0",
               out_valid, out_state, in_ready);
    end
    step();
    #3 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rstmid_ghost out_valid_cycles=%0d required=0", seen);
    end
    send(128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b0);
    wait_valid(lat);
    checks++;
    if (!out_valid || out_state !==
        ref_inv(128'h0f0e0d0c_0b0a0908_07060504_03020100)) begin
      failures++;
      $display("FAIL rstmid_after ov=%0b got=%h", out_valid, out_state);
    end
    step();
  endtask

  // drain one result under random out_ready, checking stability
  task automatic drain_rand(
    input string        name,
    input logic [127:0] exp,
    input int           idx
  );
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        checks++;
        if (out_state !== exp) begin
          failures++;
          $display("FAIL %s%0d got=%h required=%h",
                   name, idx, out_state, exp);
        end
        done = 1'b1;
      end
      step();
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s%0d_timeout out_valid=%0b required=1",
               name, idx, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [127:0] s;
    logic         b;
    for (int i = 0; i < 1000; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      b = 1'($urandom_range(0, 1));
      send(s, b);
      drain_rand("rand", b ? s : ref_inv(s), i);
    end
  endtask

  task automatic test_roundtrip();
    logic [127:0] x;
    for (int i = 0; i < 20; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      send(ref_fwd(x), 1'b0);
      drain_rand("roundtrip", x, i);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_roundtrip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
